ex_mem_stage: RTL and testbench

- Consumer end of the ID/EX pipeline register: takes the ID/EX outputs and executes them (ALU control decode, operand forwarding, 64-bit ALU, branch target/decision).
- Registers the results into the EX/MEM pipeline register using a valid/ready handshake.
- Generates the registered branch-redirect signal used to flush fetch/decode.
- Sits between the ID/EX register and the data-memory stage.

---
 rtl/ex_mem_stage.sv | 165 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Brief    : Execute stage (ALU control, forwarding, 64-bit ALU, branch
//            target/decision) feeding the EX/MEM register via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
    parameter int XLEN = 64,
    parameter int RDW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IDEX_valid,
    output logic            IDEX_ready,
    input  logic [XLEN-1:0] IDEX_PC_Out,
    input  logic [XLEN-1:0] IDEX_ReadData1,
    input  logic [XLEN-1:0] IDEX_ReadData2,
    input  logic [XLEN-1:0] IDEX_imm_data,
    input  logic [3:0]      IDEX_inst1,
    input  logic [RDW-1:0]  IDEX_inst2,
    input  logic [1:0]      IDEX_ALUOp,
    input  logic            IDEX_Branch,
    input  logic            IDEX_MemRead,
    input  logic            IDEX_MemtoReg,
    input  logic            IDEX_MemWrite,
    input  logic            IDEX_ALUSrc,
    input  logic            IDEX_Regwrite,
    input  logic [1:0]      ForwardA,
    input  logic [1:0]      ForwardB,
    input  logic [XLEN-1:0] MEMWB_data,
    input  logic            flush,
    input  logic            EXMEM_ready,
    output logic            EXMEM_valid,
    output logic [XLEN-1:0] EXMEM_ALU_Result,
    output logic [XLEN-1:0] EXMEM_WriteData,
    output logic [XLEN-1:0] EXMEM_Branch_Target,
    output logic            EXMEM_Zero,
    output logic            EXMEM_PCSrc,
    output logic [RDW-1:0]  EXMEM_rd,
    output logic            EXMEM_MemRead,
    output logic            EXMEM_MemtoReg,
    output logic            EXMEM_MemWrite,
    output logic            EXMEM_Regwrite
);

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_SLL = 3'd5;
    localparam logic [2:0] c_OP_SRL = 3'd6;
    localparam logic [2:0] c_OP_SRA = 3'd7;

    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] w_target;
    logic [5:0]      w_shamt;
    logic [2:0]      w_op;
    logic            w_zero;
    logic            w_capture;

    // Ready must never depend on IDEX_valid to avoid a combinational loop upstream.
    assign IDEX_ready = !EXMEM_valid || EXMEM_ready;
    assign w_capture  = IDEX_valid && IDEX_ready;

    always_comb begin
        w_fwd_a = IDEX_ReadData1;
        case (ForwardA)
            2'b10:   w_fwd_a = EXMEM_ALU_Result;
            2'b01:   w_fwd_a = MEMWB_data;
            default: w_fwd_a = IDEX_ReadData1;
        endcase
    end

    always_comb begin
        w_fwd_b = IDEX_ReadData2;
        case (ForwardB)
            2'b10:   w_fwd_b = EXMEM_ALU_Result;
            2'b01:   w_fwd_b = MEMWB_data;
            default: w_fwd_b = IDEX_ReadData2;
        endcase
    end

    assign w_alu_b = IDEX_ALUSrc ? IDEX_imm_data : w_fwd_b;
    assign w_shamt = w_alu_b[5:0];

    always_comb begin
        w_op = c_OP_ADD;
        case (IDEX_ALUOp)
            2'b01: w_op = c_OP_SUB;
            2'b10: begin
                case (IDEX_inst1)
                    4'b1000: w_op = c_OP_SUB;
                    4'b0111: w_op = c_OP_AND;
                    4'b0110: w_op = c_OP_OR;
                    4'b0100: w_op = c_OP_XOR;
                    4'b0001: w_op = c_OP_SLL;
                    4'b0101: w_op = c_OP_SRL;
                    4'b1101: w_op = c_OP_SRA;
                    default: w_op = c_OP_ADD;
                endcase
            end
            default: w_op = c_OP_ADD;
        endcase
    end

    always_comb begin
        w_result = w_fwd_a + w_alu_b;
        case (w_op)
            c_OP_SUB: w_result = w_fwd_a - w_alu_b;
            c_OP_AND: w_result = w_fwd_a & w_alu_b;
            c_OP_OR:  w_result = w_fwd_a | w_alu_b;
            c_OP_XOR: w_result = w_fwd_a ^ w_alu_b;
            c_OP_SLL: w_result = w_fwd_a << w_shamt;
            c_OP_SRL: w_result = w_fwd_a >> w_shamt;
            c_OP_SRA: w_result = $unsigned($signed(w_fwd_a) >>> w_shamt);
            default:  w_result = w_fwd_a + w_alu_b;
        endcase
    end

    assign w_zero   = (w_result == '0);
    assign w_target = IDEX_PC_Out + (IDEX_imm_data << 1);

    // Stall (IDEX_ready low) falls through every branch and holds all outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            EXMEM_valid         <= 1'b0;
            EXMEM_ALU_Result    <= '0;
            EXMEM_WriteData     <= '0;
            EXMEM_Branch_Target <= '0;
            EXMEM_Zero          <= 1'b0;
            EXMEM_PCSrc         <= 1'b0;
            EXMEM_rd            <= '0;
            EXMEM_MemRead       <= 1'b0;
            EXMEM_MemtoReg      <= 1'b0;
            EXMEM_MemWrite      <= 1'b0;
            EXMEM_Regwrite      <= 1'b0;
        end else if (w_capture) begin
            EXMEM_valid         <= !flush;
            EXMEM_ALU_Result    <= w_result;
            EXMEM_WriteData     <= w_fwd_b;
            EXMEM_Branch_Target <= w_target;
            EXMEM_Zero          <= w_zero;
            EXMEM_PCSrc         <= !flush && IDEX_Branch && w_zero;
            EXMEM_rd            <= IDEX_inst2;
            EXMEM_MemRead       <= !flush && IDEX_MemRead;
            EXMEM_MemtoReg      <= !flush && IDEX_MemtoReg;
            EXMEM_MemWrite      <= !flush && IDEX_MemWrite;
            EXMEM_Regwrite      <= !flush && IDEX_Regwrite;
        end else if (IDEX_ready) begin
            EXMEM_valid         <= 1'b0;
            EXMEM_PCSrc         <= 1'b0;
            EXMEM_MemRead       <= 1'b0;
            EXMEM_MemtoReg      <= 1'b0;
            EXMEM_MemWrite      <= 1'b0;
            EXMEM_Regwrite      <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Brief    : Randomized and directed self-checking bench for ex_mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

    localparam int XLEN = 64;
    localparam int RDW  = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            IDEX_valid;
    logic            IDEX_ready;
    logic [XLEN-1:0] IDEX_PC_Out, IDEX_ReadData1, IDEX_ReadData2, IDEX_imm_data;
    logic [3:0]      IDEX_inst1;
    logic [RDW-1:0]  IDEX_inst2;
    logic [1:0]      IDEX_ALUOp;
    logic            IDEX_Branch, IDEX_MemRead, IDEX_MemtoReg, IDEX_MemWrite;
    logic            IDEX_ALUSrc, IDEX_Regwrite;
    logic [1:0]      ForwardA, ForwardB;
    logic [XLEN-1:0] MEMWB_data;
    logic            flush;
    logic            EXMEM_ready;
    logic            EXMEM_valid;
    logic [XLEN-1:0] EXMEM_ALU_Result, EXMEM_WriteData, EXMEM_Branch_Target;
    logic            EXMEM_Zero, EXMEM_PCSrc;
    logic [RDW-1:0]  EXMEM_rd;
    logic            EXMEM_MemRead, EXMEM_MemtoReg, EXMEM_MemWrite, EXMEM_Regwrite;

    ex_mem_stage #(.XLEN(XLEN), .RDW(RDW)) dut (
        .clk(clk), .reset(reset),
        .IDEX_valid(IDEX_valid), .IDEX_ready(IDEX_ready),
        .IDEX_PC_Out(IDEX_PC_Out), .IDEX_ReadData1(IDEX_ReadData1),
        .IDEX_ReadData2(IDEX_ReadData2), .IDEX_imm_data(IDEX_imm_data),
        .IDEX_inst1(IDEX_inst1), .IDEX_inst2(IDEX_inst2), .IDEX_ALUOp(IDEX_ALUOp),
        .IDEX_Branch(IDEX_Branch), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_MemWrite(IDEX_MemWrite),
        .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_Regwrite(IDEX_Regwrite),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .MEMWB_data(MEMWB_data),
        .flush(flush), .EXMEM_ready(EXMEM_ready), .EXMEM_valid(EXMEM_valid),
        .EXMEM_ALU_Result(EXMEM_ALU_Result), .EXMEM_WriteData(EXMEM_WriteData),
        .EXMEM_Branch_Target(EXMEM_Branch_Target), .EXMEM_Zero(EXMEM_Zero),
        .EXMEM_PCSrc(EXMEM_PCSrc), .EXMEM_rd(EXMEM_rd),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemtoReg(EXMEM_MemtoReg),
        .EXMEM_MemWrite(EXMEM_MemWrite), .EXMEM_Regwrite(EXMEM_Regwrite)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference copy of the EX/MEM register contents.
    logic            m_valid, m_zero, m_pcsrc, m_mr, m_m2r, m_mw, m_rw, m_known;
    logic [XLEN-1:0] m_alu, m_wd, m_tgt;
    logic [RDW-1:0]  m_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_alu(input logic [1:0] aluop, input logic [3:0] f,
                                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int sh = int'(b[5:0]);
        if (aluop == 2'b01) return a - b;
        if (aluop != 2'b10) return a + b;
        if (f == 4'b1000) return a - b;
        if (f == 4'b0111) return a & b;
        if (f == 4'b0110) return a | b;
        if (f == 4'b0100) return a ^ b;
        if (f == 4'b0001) return a << sh;
        if (f == 4'b0101) return a >> sh;
        if (f == 4'b1101) return $unsigned($signed(a) >>> sh);
        return a + b;
    endfunction

    function automatic logic [XLEN-1:0] pick(input logic [1:0] sel, input logic [XLEN-1:0] idex,
                                              input logic [XLEN-1:0] exm, input logic [XLEN-1:0] wb);
        if (sel == 2'b10) return exm;
        if (sel == 2'b01) return wb;
        return idex;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_zero = 0; m_pcsrc = 0; m_mr = 0; m_m2r = 0; m_mw = 0; m_rw = 0;
        m_alu = '0; m_wd = '0; m_tgt = '0; m_rd = '0; m_known = 1;
    endtask

    task automatic model_edge();
        logic [XLEN-1:0] a, fb, res;
        if (m_valid && !EXMEM_ready) return;
        if (IDEX_valid) begin
            a   = pick(ForwardA, IDEX_ReadData1, m_alu, MEMWB_data);
            fb  = pick(ForwardB, IDEX_ReadData2, m_alu, MEMWB_data);
            res = ref_alu(IDEX_ALUOp, IDEX_inst1, a, IDEX_ALUSrc ? IDEX_imm_data : fb);
            m_alu = res; m_wd = fb; m_zero = (res == 0); m_rd = IDEX_inst2;
            m_tgt = IDEX_PC_Out + IDEX_imm_data * 2;
            m_valid = !flush;
            m_pcsrc = !flush && IDEX_Branch && (res == 0);
            m_mr = !flush && IDEX_MemRead;  m_m2r = !flush && IDEX_MemtoReg;
            m_mw = !flush && IDEX_MemWrite; m_rw  = !flush && IDEX_Regwrite;
            m_known = 1;
        end else begin
            m_valid = 0; m_pcsrc = 0; m_mr = 0; m_m2r = 0; m_mw = 0; m_rw = 0;
            m_known = 0;
        end
    endtask

    task automatic check_outputs();
        check("valid", EXMEM_valid, m_valid);
        check("pcsrc", EXMEM_PCSrc, m_pcsrc);
        check("ctrl", {EXMEM_MemRead, EXMEM_MemtoReg, EXMEM_MemWrite, EXMEM_Regwrite},
              {m_mr, m_m2r, m_mw, m_rw});
        if (m_valid) begin
            check("alu_result", EXMEM_ALU_Result, m_alu);
            check("write_data", EXMEM_WriteData, m_wd);
            check("br_target", EXMEM_Branch_Target, m_tgt);
            check("zero", EXMEM_Zero, m_zero);
            check("rd", EXMEM_rd, m_rd);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1 check("idex_ready", IDEX_ready, !m_valid || EXMEM_ready);
        @(posedge clk);
        model_edge();
        #1 check_outputs();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        IDEX_valid = 0; IDEX_PC_Out = '0; IDEX_ReadData1 = '0; IDEX_ReadData2 = '0;
        IDEX_imm_data = '0; IDEX_inst1 = '0; IDEX_inst2 = '0; IDEX_ALUOp = '0;
        IDEX_Branch = 0; IDEX_MemRead = 0; IDEX_MemtoReg = 0; IDEX_MemWrite = 0;
        IDEX_ALUSrc = 0; IDEX_Regwrite = 0; ForwardA = 0; ForwardB = 0;
        MEMWB_data = '0; flush = 0; EXMEM_ready = 1;
    endtask

    task automatic rand_inputs(input bit allow_exm_fwd);
        logic [3:0] codes [9] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
                                  4'b0001, 4'b0101, 4'b1101, 4'b0011};
        IDEX_valid     = ($urandom_range(0, 9) < 8);
        IDEX_PC_Out    = {$urandom, $urandom};
        IDEX_ReadData1 = {$urandom, $urandom};
        IDEX_ReadData2 = ($urandom_range(0, 3) == 0) ? IDEX_ReadData1 : {$urandom, $urandom};
        IDEX_imm_data  = {$urandom, $urandom};
        IDEX_inst1     = codes[$urandom_range(0, 8)];
        IDEX_inst2     = RDW'($urandom);
        IDEX_ALUOp     = 2'($urandom);
        {IDEX_Branch, IDEX_MemRead, IDEX_MemtoReg, IDEX_MemWrite, IDEX_ALUSrc, IDEX_Regwrite}
            = 6'($urandom);
        ForwardA       = 2'($urandom);
        ForwardB       = 2'($urandom);
        if (!allow_exm_fwd && ForwardA == 2'b10) ForwardA = 2'b00;
        if (!allow_exm_fwd && ForwardB == 2'b10) ForwardB = 2'b11;
        MEMWB_data     = {$urandom, $urandom};
        flush          = ($urandom_range(0, 9) == 0);
        EXMEM_ready    = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 0;
        repeat (2) @(negedge clk);
        check("reset_valid", EXMEM_valid, 0);
        check("reset_result", EXMEM_ALU_Result, 0);
        reset = 1;

        // R-type add
        IDEX_valid = 1; IDEX_ReadData1 = 5; IDEX_ReadData2 = 7; IDEX_ALUOp = 2'b10;
        IDEX_inst1 = 4'b0000; IDEX_inst2 = 3; IDEX_Regwrite = 1;
        step();
        check("add_result", EXMEM_ALU_Result, 12);
        check("add_rd", EXMEM_rd, 3);

        // beq taken, then the same with flush
        idle_inputs();
        IDEX_valid = 1; IDEX_ALUOp = 2'b01; IDEX_ReadData1 = 9; IDEX_ReadData2 = 9;
        IDEX_Branch = 1; IDEX_PC_Out = 64'h100; IDEX_imm_data = 64'h10;
        step();
        check("beq_pcsrc", EXMEM_PCSrc, 1);
        check("beq_target", EXMEM_Branch_Target, 64'h120);
        flush = 1; IDEX_Regwrite = 1;
        step();
        check("beq_flush_valid", EXMEM_valid, 0);
        check("beq_flush_pcsrc", EXMEM_PCSrc, 0);

        // Forwarding: 0x40 into EX/MEM, then forward it with imm 8
        idle_inputs();
        IDEX_valid = 1; IDEX_ReadData1 = 64'h40;
        step();
        ForwardA = 2'b10; IDEX_ReadData1 = 0; IDEX_imm_data = 8; IDEX_ALUSrc = 1;
        step();
        check("fwd_exmem", EXMEM_ALU_Result, 64'h48);
        ForwardA = 2'b00; ForwardB = 2'b01; MEMWB_data = 64'hAA; IDEX_MemWrite = 1;
        step();
        check("fwd_memwb_wd", EXMEM_WriteData, 64'hAA);

        // sra and wrap-around add
        idle_inputs();
        IDEX_valid = 1; IDEX_ALUOp = 2'b10; IDEX_inst1 = 4'b1101;
        IDEX_ReadData1 = 64'h8000_0000_0000_0000; IDEX_ReadData2 = 4;
        step();
        check("sra", EXMEM_ALU_Result, 64'hF800_0000_0000_0000);
        IDEX_ALUOp = 2'b00; IDEX_ReadData1 = '1; IDEX_ReadData2 = 1;
        step();
        check("wrap_result", EXMEM_ALU_Result, 0);
        check("wrap_zero", EXMEM_Zero, 1);

        // Stall for 3 cycles with changing inputs, then release
        EXMEM_ready = 0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs(1'b1);
            IDEX_valid = 1; EXMEM_ready = 0;
            step();
        end
        check("stall_hold_result", EXMEM_ALU_Result, 0);
        idle_inputs();
        IDEX_valid = 1; IDEX_ReadData1 = 21; IDEX_ReadData2 = 21;
        step();
        check("stall_release", EXMEM_ALU_Result, 42);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs(m_known);
            step();
        end

        // Asynchronous reset while stalled with a valid entry
        idle_inputs();
        IDEX_valid = 1; IDEX_Regwrite = 1; IDEX_MemRead = 1; IDEX_Branch = 1;
        step();
        EXMEM_ready = 0;
        #2 reset = 0;
        model_reset();
        #1;
        check("async_valid", EXMEM_valid, 0);
        check("async_pcsrc", EXMEM_PCSrc, 0);
        check("async_ctrl", {EXMEM_MemRead, EXMEM_MemtoReg, EXMEM_MemWrite, EXMEM_Regwrite}, 0);
        check("async_ready", IDEX_ready, 1);
        @(negedge clk);
        reset = 1;
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
